// File: rtl/mmio_initiator.sv
// mmio_initiator: single-outstanding MMIO bus master with byte-lane steering, hold stalls and
// load extension. Define MMIO_TIMEOUT_EN to abort accesses held for TIMEOUT_CYCLES cycles.

module mmio_initiator_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic        be,
  output logic [7:0]  din
);
  localparam logic [1:0] L = 2'(LANE);

  // Narrow stores replicate the source bytes across every lane; be picks the live ones.
  always_comb begin
    be  = 1'b0;
    din = 8'h00;
    case (size)
      2'd0: begin
        be  = (off == L);
        din = wdata[7:0];
      end
      2'd1: begin
        be  = (off[1] == L[1]);
        din = L[0] ? wdata[15:8] : wdata[7:0];
      end
      2'd2: begin
        be  = 1'b1;
        din = wdata[8*LANE +: 8];
      end
      default: begin
        be  = 1'b0;
        din = 8'h00;
      end
    endcase
  end
endmodule

module mmio_initiator #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mmio_en,
  output logic        mmio_we,
  output logic [29:0] mmio_waddr,
  output logic [3:0]  mmio_be,
  output logic [31:0] mmio_din,
  input  logic [31:0] mmio_dout,
  input  logic        mmio_hold
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

  typedef struct packed {
    logic [1:0] size;
    logic [1:0] off;
    logic       uns;
  } ld_t;

  state_t                           state;
  ld_t                              ld;
  logic [NUM_LANES-1:0]             be_c;
  logic [NUM_LANES-1:0][7:0]        din_c;
  logic                             accept;
  logic                             illegal;
  logic [31:0]                      shifted;
  logic [31:0]                      ext;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    mmio_initiator_lane #(.LANE(gi)) u_lane (
      .size  (req_size),
      .off   (req_addr[1:0]),
      .wdata (req_wdata),
      .be    (be_c[gi]),
      .din   (din_c[gi])
    );
  end

  // A non-positive limit has no meaningful timeout; nothing extra is built for it.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_degenerate
  end

`ifdef MMIO_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] hold_cnt;
`endif

  assign accept  = req_valid & req_ready;
  assign illegal = (req_size == 2'd3) ||
                   (req_size == 2'd1 && req_addr[0]) ||
                   (req_size == 2'd2 && req_addr[1:0] != 2'b00);

  assign shifted = mmio_dout >> {ld.off, 3'b000};

  always_comb begin
    ext = shifted;
    case (ld.size)
      2'd0:    ext = ld.uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    ext = ld.uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      ld         <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
      mmio_en    <= 1'b0;
      mmio_we    <= 1'b0;
      mmio_waddr <= 30'h0;
      mmio_be    <= 4'h0;
      mmio_din   <= 32'h0;
`ifdef MMIO_TIMEOUT_EN
      hold_cnt   <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
      case (state)
        IDLE: begin
          // Ready stays low through any response cycle and rises the cycle after.
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            ld        <= '{size: req_size, off: req_addr[1:0], uns: req_unsigned};
            if (illegal) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state      <= ACCESS;
              mmio_en    <= 1'b1;
              mmio_we    <= req_we;
              mmio_waddr <= req_addr[31:2];
              mmio_be    <= be_c;
              mmio_din   <= din_c;
`ifdef MMIO_TIMEOUT_EN
              hold_cnt   <= '0;
`endif
            end
          end
        end
        ACCESS: begin
          if (!mmio_hold) begin
            mmio_en    <= 1'b0;
            mmio_we    <= 1'b0;
            mmio_waddr <= 30'h0;
            mmio_be    <= 4'h0;
            mmio_din   <= 32'h0;
            state      <= mmio_we ? IDLE : RDATA;
            resp_valid <= mmio_we;
          end
`ifdef MMIO_TIMEOUT_EN
          else if (hold_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            mmio_en    <= 1'b0;
            mmio_we    <= 1'b0;
            mmio_waddr <= 30'h0;
            mmio_be    <= 4'h0;
            mmio_din   <= 32'h0;
            state      <= IDLE;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
`endif
        end
        RDATA: begin
          resp_valid <= 1'b1;
          resp_rdata <= ext;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_initiator.sv
// Bench for mmio_initiator: a transaction-level model predicts every output for every cycle,
// and a single negedge process compares the DUT against that per-cycle expectation table.

module tb_mmio_initiator;
  localparam int TO   = 4;
  localparam int NCYC = 8192;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic [1:0]  req_size = 2'd0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mmio_en, mmio_we;
  logic [29:0] mmio_waddr;
  logic [3:0]  mmio_be;
  logic [31:0] mmio_din;
  logic [31:0] mmio_dout = 32'h0;
  logic        mmio_hold = 1'b0;

  always #5 CLK = ~CLK;

  mmio_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mmio_en(mmio_en), .mmio_we(mmio_we), .mmio_waddr(mmio_waddr), .mmio_be(mmio_be),
    .mmio_din(mmio_din), .mmio_dout(mmio_dout), .mmio_hold(mmio_hold)
  );

  typedef struct packed {
    logic        ready, en, we;
    logic [29:0] waddr;
    logic [3:0]  be;
    logic [31:0] din;
    logic        rv, re;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q [NCYC];
  bit   exp_v [NCYC];
  exp_t ce;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
    end
  endtask

  always @(negedge CLK) begin
    if (cyc < NCYC && exp_v[cyc]) begin
      ce = exp_q[cyc];
      chk("req_ready",  32'(req_ready),  32'(ce.ready));
      chk("mmio_en",    32'(mmio_en),    32'(ce.en));
      chk("mmio_we",    32'(mmio_we),    32'(ce.we));
      chk("mmio_waddr", 32'(mmio_waddr), 32'(ce.waddr));
      chk("mmio_be",    32'(mmio_be),    32'(ce.be));
      chk("mmio_din",   mmio_din,        ce.din);
      chk("resp_valid", 32'(resp_valid), 32'(ce.rv));
      chk("resp_err",   32'(resp_err),   32'(ce.re));
      chk("resp_rdata", resp_rdata,      ce.rd);
    end
  end

  // ---- behavioural model ----
  function automatic bit m_legal(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'd0:    return 1'b1;
      2'd1:    return a[0] == 1'b0;
      2'd2:    return a[1:0] == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'd0:    return 4'(1 << a[1:0]);
      2'd1:    return 4'(3 << a[1:0]);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_din(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'd0:    return {4{wd[7:0]}};
      2'd1:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a,
                                         input logic uns, input logic [31:0] d);
    logic [31:0] s;
    s = d >> (8 * a[1:0]);
    case (sz)
      2'd0:    return uns ? (s & 32'hFF)   : {{24{s[7]}}, s[7:0]};
      2'd1:    return uns ? (s & 32'hFFFF) : {{16{s[15]}}, s[15:0]};
      default: return s;
    endcase
  endfunction

  function automatic exp_t idle_e(input logic rdy);
    exp_t e;
    e = '0;
    e.ready = rdy;
    return e;
  endfunction

  task automatic set_exp(input exp_t e);
    if (cyc < NCYC) begin
      exp_q[cyc] = e;
      exp_v[cyc] = 1'b1;
    end
  endtask

  // Advance one cycle; inputs the DUT must ignore get random garbage.
  task automatic step();
    @(posedge CLK);
    #1;
    mmio_hold    = 1'($urandom);
    mmio_dout    = $urandom;
    req_valid    = 1'($urandom);
    req_we       = 1'($urandom);
    req_addr     = $urandom;
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_wdata    = $urandom;
  endtask

  task automatic txn(input logic we, input logic [31:0] a, input logic [1:0] sz, input logic uns,
                     input logic [31:0] wd, input int hold, input logic [31:0] dout, input int gap,
                     input logic [3:0] xbe, input logic [31:0] xdin, input logic [31:0] xrd,
                     input bit xerr);
    exp_t e;
    for (int i = 0; i < gap; i++) begin
      req_valid = 1'b0;
      set_exp(idle_e(1'b1));
      step();
    end
    req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz;
    req_unsigned = uns; req_wdata = wd;
    set_exp(idle_e(1'b1));
    step();
    if (xerr) begin
      e = '0; e.rv = 1'b1; e.re = 1'b1;
      set_exp(e);
      step();
      return;
    end
    e = '0; e.en = 1'b1; e.we = we; e.waddr = a[31:2]; e.be = xbe; e.din = xdin;
    for (int i = 0; i <= hold; i++) begin
      mmio_hold = (i < hold);
      set_exp(e);
      step();
    end
    if (we) begin
      e = '0; e.rv = 1'b1;
      set_exp(e);
      step();
      return;
    end
    mmio_dout = dout;
    set_exp(idle_e(1'b0));
    step();
    e = '0; e.rv = 1'b1; e.rd = xrd;
    set_exp(e);
    step();
  endtask

  task automatic rnd_txn();
    logic        we, uns;
    logic [1:0]  sz;
    logic [31:0] a, wd, d;
    int          hold, gap;
    we   = 1'($urandom);
    uns  = 1'($urandom);
    sz   = 2'($urandom);
    a    = $urandom;
    wd   = $urandom;
    d    = $urandom;
    hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
    gap  = $urandom_range(0, 2);
    txn(we, a, sz, uns, wd, hold, d, gap, m_be(sz, a), m_din(sz, wd),
        m_load(sz, a, uns, d), !m_legal(sz, a));
  endtask

  initial begin
    exp_t e;
    step();
    set_exp(idle_e(1'b0));
    step();
    set_exp(idle_e(1'b0));
    RST = 1'b0;
    step();

    // Hand-computed expectations.
    txn(1'b1, 32'h11080000, 2'd2, 1'b0, 32'h1234ABCD, 0, 32'h0, 0, 4'hF, 32'h1234ABCD, 32'h0, 1'b0);
    txn(1'b0, 32'h11000001, 2'd0, 1'b0, 32'h0, 0, 32'h000080FF, 1, 4'b0010, 32'h0, 32'hFFFFFF80, 1'b0);
    txn(1'b0, 32'h11000001, 2'd0, 1'b1, 32'h0, 0, 32'h000080FF, 0, 4'b0010, 32'h0, 32'h00000080, 1'b0);
    txn(1'b1, 32'h110C0002, 2'd1, 1'b0, 32'h0000BEEF, 0, 32'h0, 0, 4'b1100, 32'hBEEFBEEF, 32'h0, 1'b0);
    txn(1'b0, 32'h11000004, 2'd2, 1'b0, 32'h0, 3, 32'hCAFEF00D, 0, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0);
    txn(1'b0, 32'h11000002, 2'd2, 1'b0, 32'h0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1'b1);
    txn(1'b1, 32'h11000000, 2'd3, 1'b0, 32'hFFFFFFFF, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1'b1);
    txn(1'b0, 32'h11000003, 2'd1, 1'b1, 32'h0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1'b1);
    txn(1'b0, 32'h11000002, 2'd1, 1'b0, 32'h12345678, 1, 32'h80010000, 0, 4'b1100, 32'h56785678,
        32'hFFFF8001, 1'b0);
    txn(1'b1, 32'h11000010, 2'd1, 1'b0, 32'hAAAA1234, 2, 32'h0, 0, 4'b0011, 32'h12341234, 32'h0, 1'b0);
    txn(1'b1, 32'h11000013, 2'd0, 1'b0, 32'h000000A5, 0, 32'h0, 0, 4'b1000, 32'hA5A5A5A5, 32'h0, 1'b0);

    for (int n = 0; n < 150; n++) rnd_txn();

    // Reset while a load is on the bus: bus drops, no response follows.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h11000008; req_size = 2'd2;
    req_unsigned = 1'b0; req_wdata = 32'h0;
    set_exp(idle_e(1'b1));
    step();
    e = '0; e.en = 1'b1; e.waddr = 30'h04400002; e.be = 4'hF;
    set_exp(e);
    mmio_hold = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    req_valid = 1'b0;
    set_exp(idle_e(1'b0));
    step();
    txn(1'b0, 32'h11000005, 2'd0, 1'b1, 32'h0, 0, 32'h0000AB00, 0, 4'b0010, 32'h0, 32'h000000AB, 1'b0);

`ifdef MMIO_TIMEOUT_EN
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h11000020; req_size = 2'd2;
    req_unsigned = 1'b0; req_wdata = 32'h55AA55AA;
    set_exp(idle_e(1'b1));
    step();
    e = '0; e.en = 1'b1; e.we = 1'b1; e.waddr = 30'h04400008; e.be = 4'hF; e.din = 32'h55AA55AA;
    for (int i = 0; i < TO; i++) begin
      mmio_hold = 1'b1;
      set_exp(e);
      step();
    end
    mmio_hold = 1'b1;
    e = '0; e.rv = 1'b1; e.re = 1'b1;
    set_exp(e);
    step();
`endif

    for (int n = 0; n < 20; n++) rnd_txn();

    req_valid = 1'b0;
    set_exp(idle_e(1'b1));
    step();
    req_valid = 1'b0;
    set_exp(idle_e(1'b1));
    @(negedge CLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
